// File: rtl/dac_output_stage.sv
// dac_output_stage: takes a 32-bit waveform sample on a strobe and applies
// signed gain and an offset around midscale. It saturates the result to a
// 12-bit code and shifts it out as a 16-bit SPI frame {DAC_CMD, code},
// MSB first. The external DAC samples MOSI on the rising edge of SCLK.
//
// Strobe protocol: sample_strobe is a one-cycle request with no ready signal.
// The request is accepted only while busy=0 (state IDLE). A request that
// arrives while busy=1 is dropped, and it sets the sticky overrun flag.
module dac_output_stage #(
   parameter int         DAC_BITS = 12,
   parameter int         CLK_DIV  = 4,
   parameter logic [3:0] DAC_CMD  = 4'b0011
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           sample_in,
   input  logic                  sample_strobe,
   input  logic [7:0]            gain,
   input  logic signed [12:0]    offset,
   input  logic                  clr_overrun,
   output logic                  busy,
   output logic                  overrun,
   output logic [DAC_BITS-1:0]   dac_code,
   output logic                  spi_cs_n,
   output logic                  spi_sclk,
   output logic                  spi_mosi,
   output logic [2:0]            dbg_state
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CALC1 = 3'd1,
      S_CALC2 = 3'd2,
      S_SHIFT = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t                  r_state;
   state_t                  w_next_state;
   logic [DAC_BITS-1:0]     r_x;
   logic signed [21:0]      r_p;
   logic signed [12:0]      r_offset;
   logic [DAC_BITS-1:0]     r_code;
   logic [15:0]             r_shreg;
   logic [DIV_W-1:0]        r_div;
   logic                    r_half;
   logic [3:0]              r_bit;
   logic                    r_overrun;

   logic signed [12:0]      w_xs;
   logic signed [21:0]      w_p;
   logic signed [21:0]      w_s;
   logic [DAC_BITS-1:0]     w_code;
   logic                    w_div_last;
   logic                    w_unused_lsbs;

   // The low sample bits fall below the DAC resolution and are discarded.
   assign w_unused_lsbs = ^sample_in[19:0];

   // Center the sample on midscale, then scale it by gain/128 (the shift comes later).
   assign w_xs = $signed({1'b0, r_x}) - 13'sd2048;
   assign w_p  = 22'(w_xs) * 22'($signed({1'b0, gain}));
   // >>> floors toward minus infinity, so -1/128 rounds to -1 and not to 0.
   assign w_s  = (r_p >>> 7) + 22'(r_offset) + 22'sd2048;

   assign w_div_last = (r_div == DIV_W'(CLK_DIV - 1));

   // Saturate the offset result into the unsigned DAC code range.
   always_comb begin
      w_code = w_s[DAC_BITS-1:0];
      if (w_s[21]) begin
         w_code = '0;
      end else if (w_s > 22'sd4095) begin
         w_code = '1;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic and the SPI and busy outputs, all decoded from the current state.
   always_comb begin
      w_next_state = r_state;
      busy         = 1'b1;
      spi_cs_n     = 1'b1;
      spi_sclk     = 1'b0;
      spi_mosi     = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (sample_strobe) w_next_state = S_CALC1;
         end
         S_CALC1: w_next_state = S_CALC2;
         S_CALC2: w_next_state = S_SHIFT;
         S_SHIFT: begin
            spi_cs_n = 1'b0;
            spi_sclk = r_half;
            spi_mosi = r_shreg[15];
            if (w_div_last && r_half && (r_bit == 4'd15)) w_next_state = S_GAP;
         end
         S_GAP: begin
            if (w_div_last) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Datapath: capture the sample, run the two arithmetic stages, then drive the shifter and the SCLK phase counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_x      <= '0;
         r_p      <= '0;
         r_offset <= '0;
         r_code   <= '0;
         r_shreg  <= '0;
         r_div    <= '0;
         r_half   <= 1'b0;
         r_bit    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (sample_strobe) r_x <= sample_in[31:20];
            end
            S_CALC1: begin
               r_p      <= w_p;
               r_offset <= offset;
            end
            S_CALC2: begin
               r_code  <= w_code;
               r_shreg <= {DAC_CMD, w_code};
               r_div   <= '0;
               r_half  <= 1'b0;
               r_bit   <= '0;
            end
            S_SHIFT: begin
               if (w_div_last) begin
                  r_div  <= '0;
                  r_half <= ~r_half;
                  // Advance to the next bit at the end of the high phase, so MOSI changes while SCLK is low.
                  if (r_half) begin
                     r_shreg <= {r_shreg[14:0], 1'b0};
                     r_bit   <= r_bit + 4'd1;
                  end
               end else begin
                  r_div <= r_div + DIV_W'(1);
               end
            end
            S_GAP: begin
               r_div <= w_div_last ? '0 : r_div + DIV_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Sticky overrun flag. A new event wins over a clear in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overrun <= 1'b0;
      end else if (sample_strobe && busy) begin
         r_overrun <= 1'b1;
      end else if (clr_overrun) begin
         r_overrun <= 1'b0;
      end
   end

   assign overrun   = r_overrun;
   assign dac_code  = r_code;
   assign dbg_state = r_state;

endmodule

// File: doc/dac_output_stage.md
Name: dac_output_stage

Overview:
- Downstream consumer of the waveform generator's 32-bit `signal` output.
- Takes a sample on a strobe and applies signed gain and offset around midscale, then saturates to a DAC_BITS code.
- Serialises the code to an external SPI DAC as a 16-bit frame: 4-bit command plus 12-bit data.
- Sits between the generator and the board DAC pins; reports busy and sticky overrun status to the control logic.

Parameters:
- DAC_BITS, 12: DAC code width. The frame layout below is fixed for 12.
- CLK_DIV, 4: SCLK half-period in clk cycles, ≥1.
- DAC_CMD, 4'b0011: command nibble sent in frame bits [15:12] ("write and update").

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_in  in  32  unsigned waveform sample from the generator.
- sample_strobe  in  1  request to convert sample_in this cycle.
- gain  in  8  unsigned gain, scale = gain/128 (128 = unity).
- offset  in  13  signed offset in DAC LSBs.
- clr_overrun  in  1  clears overrun.
- busy  out  1  conversion/frame in progress; strobes are ignored while high.
- overrun  out  1  sticky: a strobe arrived while busy.
- dac_code  out  12  last computed saturated code.
- spi_cs_n  out  1  DAC chip select, active low.
- spi_sclk  out  1  SPI clock, idles low.
- spi_mosi  out  1  serial data, MSB first.

Behaviour:
- Reset is synchronous, active-high. On rst, next edge: state=IDLE; busy=0, overrun=0, dac_code=0, spi_cs_n=1, spi_sclk=0, spi_mosi=0. Reset mid-frame aborts the frame immediately with the same values and no trailing SCLK edge.
- Accept: in cycle T, sample_strobe=1 with state=IDLE captures x = sample_in[31:20]. State goes to CALC1 and busy=1 from T+1.
- Strobe while busy=1: sample is dropped and overrun is set. clr_overrun clears it. If clr_overrun and a new overrun event occur in the same cycle, set wins.
- CALC1 (T+1):
  - xs = {1'b0,x} − 2048, signed 13-bit.
  - p = xs × {1'b0,gain}, signed 22-bit, registered.
  - gain and offset are sampled in this cycle.
- CALC2 (T+2):
  - s = (p >>> 7) + offset + 2048, arithmetic shift (floor), full-width signed.
  - code = clamp(s, 0, 4095), registered into dac_code and the shift register as {DAC_CMD, code}.
- SHIFT:
  - From T+3, spi_cs_n=0.
  - Each of the 16 bits occupies 2·CLK_DIV cycles: spi_sclk low for the first CLK_DIV cycles, high for the next CLK_DIV.
  - spi_mosi changes only while sclk is low, at the start of each bit; the DAC samples on the rising edge.
  - Bit 15 is presented in the first SHIFT cycle.
- GAP: after the 16th high phase, spi_cs_n=1, spi_sclk=0, spi_mosi=0 for CLK_DIV cycles, then IDLE with busy=0.
- Frame timing: busy is high for exactly 2 + 32·CLK_DIV + CLK_DIV cycles (134 at CLK_DIV=4). A strobe in the first cycle busy=0 is accepted.
- Transitions: IDLE→CALC1→CALC2→SHIFT→GAP→IDLE. No other paths except reset.
- dac_code holds its value between frames.

Test Plan:
- gain=128, offset=0, sample_in=32'h8000_0000 → dac_code=12'h800; MOSI frame 16'h3800; 16 rising SCLK edges; cs_n low 128 cycles; busy 134 cycles.
- gain=128, offset=0, sample_in=32'hFFF0_0000 → code 4095, frame 16'h3FFF. Same sample with gain=255 → 2047·255>>7=4077, s=6125, saturated to 4095.
- gain=128, offset=−2048, sample_in=0 → s=−2048, clamped to 0, frame 16'h3000. gain=0, offset=+5, any sample → code 2053.
- Second strobe 10 cycles after accept → ignored, overrun=1 and held. clr_overrun pulse → overrun=0. Strobe on first idle cycle → accepted, back-to-back frames.
- Assert rst during bit 7 of a frame → next edge cs_n=1, sclk=0, mosi=0, busy=0; a following strobe starts a clean frame.
- CLK_DIV=1 build → SCLK toggles every cycle, busy lasts 35 cycles, data matches the first scenario.
